score_display_mux: RTL and testbench

- Parametrised multi-player BCD score keeper with a time-multiplexed common-anode 7-segment driver.
- Sits on the arcade peripheral bus: game logic writes per-player increment/clear commands, the block keeps decimal scores, detects the winning score and scans all digits onto one cathode bus.
- Next generation of the fixed 2-player/2-digit scoreboard: adds generic player and digit counts, a programmable win score, clear commands, a game-over FSM and winner display.

---
 rtl/score_display_mux.sv | 170 +++++++++++++++++
 tb/tb_score_display_mux.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_mux.sv
// Multi-player BCD score keeper with game-over FSM and a scanned common-anode 7-segment driver.
// Optional build macro SCORE_BLANK_LZ_EN blanks leading zeros of each displayed score.
module score_display_mux #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned SCAN_DIV    = 16,
  parameter int unsigned WIN_SCORE   = 99
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sel,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [1:0]                    wdata,
  output logic [7:0]                    cathode,
  output logic [NUM_PLAYERS*DIGITS-1:0] anode,
  output logic                          game_over,
  output logic [ADDR_W-1:0]             winner
);

  localparam int unsigned NDIG  = NUM_PLAYERS * DIGITS;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0]  DASH  = 8'b1011_1111;

  typedef logic [DIGITS-1:0][3:0] score_t;
  typedef enum logic {PLAY, OVER} state_e;

  function automatic score_t win_bcd();
    score_t      r;
    int unsigned v;
    r = '0;
    v = WIN_SCORE;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      r[k] = 4'(v % 10);
      v    = v / 10;
    end
    return r;
  endfunction

  localparam score_t WIN_BCD = win_bcd();

  function automatic logic [7:0] seg(logic [3:0] v);
    case (v)
      4'd0:    return 8'b1100_0000;
      4'd1:    return 8'b1111_1001;
      4'd2:    return 8'b1010_0100;
      4'd3:    return 8'b1011_0000;
      4'd4:    return 8'b1001_1001;
      4'd5:    return 8'b1001_0010;
      4'd6:    return 8'b1000_0010;
      4'd7:    return 8'b1111_1000;
      4'd8:    return 8'b1000_0000;
      4'd9:    return 8'b1001_0000;
      default: return DASH;
    endcase
  endfunction

  score_t [NUM_PLAYERS-1:0] score_q, score_d;
  logic                     cmd_vld_q, cmd_vld_d;
  logic [ADDR_W-1:0]        cmd_addr_q, cmd_addr_d;
  logic [1:0]               cmd_wdata_q, cmd_wdata_d;
  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        winner_q, winner_d;
  logic [SCAN_DIV-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]         scan_idx_q, scan_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q     <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      state_q     <= PLAY;
      winner_q    <= '0;
      presc_q     <= '0;
      scan_idx_q  <= '0;
    end else begin
      score_q     <= score_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      state_q     <= state_d;
      winner_q    <= winner_d;
      presc_q     <= presc_d;
      scan_idx_q  <= scan_idx_d;
    end
  end

  always_comb begin
    cmd_vld_d   = sel && (32'(addr) < NUM_PLAYERS);
    cmd_addr_d  = addr;
    cmd_wdata_d = wdata;
  end

  // Score update and game FSM; the win check uses the freshly incremented value.
  always_comb begin
    score_t nxt;
    logic   carry;
    score_d  = score_q;
    state_d  = state_q;
    winner_d = winner_q;
    nxt      = '0;
    carry    = 1'b0;
    if ((state_q == PLAY) && cmd_vld_q) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        if (cmd_addr_q == ADDR_W'(p)) begin
          if (cmd_wdata_q[1]) begin
            score_d[p] = '0;
          end else if (cmd_wdata_q[0]) begin
            nxt   = score_q[p];
            carry = 1'b1;
            for (int unsigned d = 0; d < DIGITS; d++) begin
              if (carry) begin
                if (nxt[d] == 4'd9) begin
                  nxt[d] = 4'd0;
                end else begin
                  nxt[d] = nxt[d] + 4'd1;
                  carry  = 1'b0;
                end
              end
            end
            score_d[p] = nxt;
            if (nxt == WIN_BCD) begin
              state_d  = OVER;
              winner_d = cmd_addr_q;
            end
          end
        end
      end
    end
  end

  always_comb begin
    presc_d    = presc_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (presc_q == '1) begin
      scan_idx_d = (scan_idx_q == IDX_W'(NDIG - 1)) ? '0 : scan_idx_q + 1'b1;
    end
  end

  always_comb begin
    logic blank;
    anode   = ~(NDIG'(1) << scan_idx_q);
    cathode = DASH;
    blank   = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (scan_idx_q == IDX_W'(p * DIGITS + d)) begin
          if ((state_q == OVER) && (winner_q != ADDR_W'(p))) begin
            cathode = DASH;
          end else begin
            cathode = seg(score_q[p][d]);
`ifdef SCORE_BLANK_LZ_EN
            // A digit is blank when it and every higher digit are zero; ones always shown.
            blank = (d > 0);
            for (int unsigned k = d; k < DIGITS; k++) begin
              if (score_q[p][k] != 4'd0) blank = 1'b0;
            end
            if (blank) cathode = 8'hFF;
`endif
          end
        end
      end
    end
  end

  assign game_over = (state_q == OVER);
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Scoreboard bench for score_display_mux: two instances (win at 99 and win at 5), fast scan.
module tb_score_display_mux;
  localparam int unsigned SD  = 2;
  localparam int unsigned PER = 1 << SD;
`ifdef SCORE_BLANK_LZ_EN
  localparam logic [7:0] BLANK = 8'hFF;
`else
  localparam logic [7:0] BLANK = 8'hC0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sel_a = 1'b0, sel_b = 1'b0;
  logic [1:0] addr_a = '0, addr_b = '0;
  logic [1:0] wdata_a = '0, wdata_b = '0;
  logic [7:0] a_cath, b_cath;
  logic [3:0] a_an, b_an;
  logic       a_go, b_go;
  logic [1:0] a_win, b_win;

  score_display_mux #(.NUM_PLAYERS(2), .DIGITS(2), .ADDR_W(2), .SCAN_DIV(SD), .WIN_SCORE(99)) dut_a (
    .clk(clk), .rst(rst), .sel(sel_a), .addr(addr_a), .wdata(wdata_a),
    .cathode(a_cath), .anode(a_an), .game_over(a_go), .winner(a_win));

  score_display_mux #(.NUM_PLAYERS(2), .DIGITS(2), .ADDR_W(2), .SCAN_DIV(SD), .WIN_SCORE(5)) dut_b (
    .clk(clk), .rst(rst), .sel(sel_b), .addr(addr_b), .wdata(wdata_b),
    .cathode(b_cath), .anode(b_an), .game_over(b_go), .winner(b_win));

  typedef struct {
    int unsigned due;
    int          sig;
    logic [7:0]  exp;
    string       name;
  } chk_t;

  chk_t        sbq[$];
  int unsigned cyc = 0;
  int unsigned e0 = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  mon_got;
  logic [3:0]  an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] obs(int s);
    case (s)
      0:       return a_cath;
      1:       return {4'b0, a_an};
      2:       return {7'b0, a_go};
      3:       return {6'b0, a_win};
      4:       return b_cath;
      5:       return {4'b0, b_an};
      6:       return {7'b0, b_go};
      default: return {6'b0, b_win};
    endcase
  endfunction

  // Monitor: compares every queued expectation once its cycle has been reached.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      chk_t e;
      e = sbq.pop_front();
      mon_got = obs(e.sig);
      n_chk++;
      if (mon_got === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, mon_got, e.exp, cyc);
    end
  end

  function automatic int unsigned idx_at(int unsigned c);
    return ((c - e0) / PER) % 4;
  endfunction

  task automatic push(int unsigned due, int sig, logic [7:0] exp, string nm);
    chk_t e;
    e.due = due; e.sig = sig; e.exp = exp; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic wr(bit b, logic [1:0] a, logic [1:0] d);
    if (b) begin sel_b = 1'b1; addr_b = a; wdata_b = d; end
    else   begin sel_a = 1'b1; addr_a = a; wdata_a = d; end
    tick();
    sel_a = 1'b0;
    sel_b = 1'b0;
  endtask

  task automatic chk_digit(bit b, int unsigned i, logic [7:0] exp, string nm);
    int unsigned c;
    c = cyc + 2;
    while (idx_at(c) != i) c++;
    push(c, b ? 4 : 0, exp, nm);
    push(c, b ? 5 : 1, {4'b0, an_tab[i]}, {nm, "_an"});
    wait_to(c);
  endtask

  task automatic align0();
    while (!(idx_at(cyc) == 0 && ((cyc - e0) % PER) == 0)) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned s;
    rst = 1'b1;
    tick();
    tick();
    e0  = cyc;
    rst = 1'b0;
    push(cyc, 1, 8'h0E, "rst_anode");
    push(cyc, 0, 8'hC0, "rst_cathode");
    push(cyc, 2, 8'h00, "rst_game_over");
    push(cyc, 3, 8'h00, "rst_winner");
    push(cyc, 6, 8'h00, "rst_b_game_over");

    n_chk++;
    if (a_an === 4'b1110) n_pass++;
    else $display("FAIL d_rst_anode: got %b expected 1110", a_an);
    n_chk++;
    if (a_cath === 8'hC0) n_pass++;
    else $display("FAIL d_rst_cathode: got %h expected c0", a_cath);
    n_chk++;
    if (a_go === 1'b0) n_pass++;
    else $display("FAIL d_rst_game_over: got %b expected 0", a_go);
    n_chk++;
    if (b_win === 2'd0) n_pass++;
    else $display("FAIL d_rst_b_winner: got %h expected 0", b_win);

    for (int i = 0; i < 9; i++) wr(0, 2'd0, 2'b01);
    chk_digit(0, 0, 8'h90, "p0_ones_9");
    chk_digit(0, 1, BLANK, "p0_tens_9");

    // Tenth increment timed inside the ones-digit window to see the 2-cycle latency.
    align0();
    sel_a = 1'b1; addr_a = 2'd0; wdata_a = 2'b01;
    tick();
    sel_a = 1'b0;
    push(cyc, 0, 8'h90, "pre_roll_ones");
    tick();
    push(cyc, 0, 8'hC0, "roll_ones");
    chk_digit(0, 1, 8'hF9, "p0_tens_10");

    wr(0, 2'd1, 2'b01); wr(0, 2'd1, 2'b01); wr(0, 2'd1, 2'b01);
    chk_digit(0, 2, 8'hB0, "p1_b2b_3");
    wr(0, 2'd1, 2'b11);
    chk_digit(0, 2, 8'hC0, "p1_clear_wins");

    wr(0, 2'd3, 2'b01);
    wr(0, 2'd2, 2'b11);
    wr(0, 2'd0, 2'b00);
    chk_digit(0, 0, 8'hC0, "p0_ones_unchanged");
    chk_digit(0, 1, 8'hF9, "p0_tens_unchanged");
    chk_digit(0, 2, 8'hC0, "p1_ones_unchanged");

    align0();
    s = cyc;
    for (int unsigned k = 0; k < 5; k++) begin
      push(s + PER * k, 1, {4'b0, an_tab[k % 4]}, "anode_seq");
      push(s + PER * k + PER - 1, 1, {4'b0, an_tab[k % 4]}, "anode_hold");
    end
    wait_to(s + PER * 5);

    for (int i = 0; i < 7; i++) wr(0, 2'd1, 2'b01);
    chk_digit(0, 3, BLANK, "p1_tens_7");
    chk_digit(0, 2, 8'hF8, "p1_ones_7");
    push(cyc, 2, 8'h00, "a_no_game_over");

    for (int i = 0; i < 4; i++) wr(1, 2'd1, 2'b01);
    tick();
    push(cyc, 6, 8'h00, "go_at_4");
    wr(1, 2'd1, 2'b01);
    push(cyc, 6, 8'h00, "go_before_apply");
    tick();
    push(cyc, 6, 8'h01, "go_set");
    push(cyc, 7, 8'h01, "winner_p1");

    n_chk++;
    if (b_go === 1'b1) n_pass++;
    else $display("FAIL d_go_set: got %b expected 1", b_go);
    n_chk++;
    if (b_win === 2'd1) n_pass++;
    else $display("FAIL d_winner_p1: got %h expected 1", b_win);

    wr(1, 2'd0, 2'b01); wr(1, 2'd1, 2'b10); wr(1, 2'd1, 2'b11); wr(1, 2'd1, 2'b01);
    chk_digit(1, 2, 8'h92, "b_p1_ones_frozen");
    chk_digit(1, 3, BLANK, "b_p1_tens");
    chk_digit(1, 0, 8'hBF, "b_p0_ones_dash");
    chk_digit(1, 1, 8'hBF, "b_p0_tens_dash");
    push(cyc, 6, 8'h01, "go_hold");
    push(cyc, 7, 8'h01, "winner_hold");

    // Reset on the same edge a command would be captured: the command must vanish.
    sel_a = 1'b1; addr_a = 2'd0; wdata_a = 2'b01;
    rst = 1'b1;
    tick();
    sel_a = 1'b0;
    rst = 1'b0;
    e0 = cyc;
    push(cyc, 1, 8'h0E, "rst2_anode");
    push(cyc, 6, 8'h00, "rst2_b_game_over");
    chk_digit(0, 0, 8'hC0, "rst_discard_ones");
    chk_digit(0, 1, BLANK, "rst_discard_tens");

    for (int k = 0; k < 100 && sbq.size() > 0; k++) tick();
    while (sbq.size() > 0) begin
      chk_t e;
      e = sbq.pop_front();
      n_chk++;
      $display("FAIL %s: got unchecked expected check by cycle %0d", e.name, e.due);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
